// File: rtl/wide_add_pkg.sv
// Shared types for the word-serial wide adder sequencer.
// Holds the FSM state encoding and the default geometry.
package wide_add_pkg;

  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned NUM_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/wide_add_sequencer.sv
// Word-serial NUM_WORDS*WORD_W add/sub around one external WORD_W adder.
// Ports: clk/rst, in_* request (valid/ready), out_* result (valid/ready),
// add_* drive and receive the attached combinational adder, LSW first.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_op1,
  input  logic [WORD_W*NUM_WORDS-1:0] in_op2,
  input  logic                        in_cin,
  input  logic                        in_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_res,
  output logic                        out_cout,
  output logic                        out_ovf,
  output logic [WORD_W-1:0]           add_op1,
  output logic [WORD_W-1:0]           add_op2,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_res,
  input  logic                        add_cout
);

  localparam int unsigned TOT_W = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [TOT_W-1:0] a_q;
  logic [TOT_W-1:0] b_q;
  logic [TOT_W-1:0] res_q;

  logic accept;
  logic last;
  logic ovf_last;

  assign in_ready = !rst &&
    ((state == IDLE) || ((state == DONE) && out_ready));

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST);

  // b_q already holds ~B for subtraction, so one rule covers both.
  assign ovf_last = (a_q[TOT_W-1] == b_q[TOT_W-1]) &&
    (add_res[WORD_W-1] != a_q[TOT_W-1]);

  assign out_res = res_q;

  always_comb begin
    add_op1 = '0;
    add_op2 = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_op1 = a_q[int'(idx)*WORD_W +: WORD_W];
      add_op2 = b_q[int'(idx)*WORD_W +: WORD_W];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= RUN;
        end
        RUN: begin
          res_q[int'(idx)*WORD_W +: WORD_W] <= add_res;
          carry_q <= add_cout;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_cout  <= add_cout;
            out_ovf   <= ovf_last;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // accept is only possible in IDLE/DONE, so it never
      // collides with the RUN-state carry update above.
      if (accept) begin
        a_q     <= in_op1;
        b_q     <= in_sub ? ~in_op2 : in_op2;
        carry_q <= in_sub | in_cin;
        idx     <= '0;
      end
    end
  end

endmodule
